// File: rtl/snoop_memory.sv
// Main-memory model for the snooping coherence bus.
// Serves read-miss / write-miss reads with a fixed response latency. Write-backs
// are applied in the cycle they are accepted. Invalidates are accepted with no
// effect on memory. After reset a sweep writes INIT_VAL to every word, one word
// per cycle, before the bus is accepted for the first time.
module snoop_memory #(
    parameter int                ADDR_W   = 3,
    parameter int                DATA_W   = 4,
    parameter int                DEPTH    = 7,
    parameter int                LATENCY  = 2,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       bus_valid,
    input  logic [2+ADDR_W+DATA_W-1:0] bus,
    output logic                       bus_ready,
    output logic [DATA_W-1:0]          mem_out,
    output logic                       mem_valid,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic                       err
);

    localparam int BUS_W  = 2 + ADDR_W + DATA_W;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int WAIT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    localparam logic [1:0] OP_READ_MISS  = 2'd0;
    localparam logic [1:0] OP_WRITE_BACK = 2'd1;
    localparam logic [1:0] OP_WRITE_MISS = 2'd2;
    localparam logic [1:0] OP_INVALIDATE = 2'd3;

    typedef enum logic [1:0] {
        S_INIT      = 2'd0,
        S_IDLE      = 2'd1,
        S_READ_WAIT = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    logic [CNT_W-1:0]  sweep_cnt;
    logic [WAIT_W-1:0] wait_cnt;

    logic [1:0]        bus_op;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_data;
    logic              in_range;

    logic              accept;
    logic              acc_read;
    logic              acc_write;
    logic              acc_err;

    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] rd_data_p0;
    logic [ADDR_W-1:0] rd_addr_p0;

    logic              resp_fire;
    logic [DATA_W-1:0] resp_data;
    logic [ADDR_W-1:0] resp_addr;

    logic [ADDR_W-1:0] sweep_idx;

    assign bus_op    = bus[BUS_W-1 -: 2];
    assign bus_addr  = bus[DATA_W +: ADDR_W];
    assign bus_data  = bus[DATA_W-1:0];
    assign in_range  = ({1'b0, bus_addr} < DEPTH_C);
    assign sweep_idx = ADDR_W'(sweep_cnt);

    // Out-of-range reads return zero instead of touching the array.
    function automatic logic [DATA_W-1:0] range_gate(input logic ok, input logic [DATA_W-1:0] d);
        return ok ? d : '0;
    endfunction

    assign rd_data = range_gate(in_range, mem[bus_addr]);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: sweep, then serve requests, stalling while a read is in flight.
    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT: begin
                if (sweep_cnt == CNT_W'(DEPTH - 1)) begin
                    state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                if (acc_read) begin
                    state_nxt = S_READ_WAIT;
                end
            end
            S_READ_WAIT: begin
                if (wait_cnt == WAIT_W'(LATENCY - 1)) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_INIT;
        endcase
    end

    // Output/decode logic: handshake and per-op acceptance strobes.
    always_comb begin
        bus_ready = (state == S_IDLE);
        accept    = bus_valid && bus_ready;
        acc_read  = accept && ((bus_op == OP_READ_MISS) || (bus_op == OP_WRITE_MISS));
        acc_write = accept && (bus_op == OP_WRITE_BACK);
        acc_err   = accept && (bus_op != OP_INVALIDATE) && !in_range;
    end

    // Sweep counter and read-wait counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            sweep_cnt <= '0;
            wait_cnt  <= '0;
        end else begin
            if (state == S_INIT) begin
                sweep_cnt <= sweep_cnt + CNT_W'(1);
            end
            if (state == S_READ_WAIT) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    // With a one-cycle latency the response is launched straight from the bus;
    // otherwise it is launched from the captured stage one cycle before it is due.
    always_comb begin
        if (LATENCY == 1) begin
            resp_fire = acc_read;
            resp_data = rd_data;
            resp_addr = bus_addr;
        end else begin
            resp_fire = (state == S_READ_WAIT) && (wait_cnt == WAIT_W'(LATENCY - 2));
            resp_data = rd_data_p0;
            resp_addr = rd_addr_p0;
        end
    end

    // Memory array: initialisation sweep, then in-range write-backs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state == S_INIT) begin
                mem[sweep_idx] <= INIT_VAL;
            end else if (acc_write && in_range) begin
                mem[bus_addr] <= bus_data;
            end
        end
    end

    // Read capture stage: data and address sampled at acceptance.
    always_ff @(posedge clock) begin
        if (acc_read) begin
            rd_data_p0 <= rd_data;
            rd_addr_p0 <= bus_addr;
        end
    end

    // Response stage: one-cycle valid/err pulses, data/address held between responses.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_valid <= 1'b0;
            err       <= 1'b0;
            mem_out   <= '0;
            mem_addr  <= '0;
        end else begin
            mem_valid <= resp_fire;
            err       <= acc_err;
            if (resp_fire) begin
                mem_out  <= resp_data;
                mem_addr <= resp_addr;
            end
        end
    end

endmodule

// File: tb/tb_snoop_memory.sv
// Bench for snoop_memory: directed scenarios plus randomized traffic, all
// checked cycle by cycle against a transaction-level model of the memory.
module tb_snoop_memory;

    localparam int ADDR_W  = 3;
    localparam int DATA_W  = 4;
    localparam int DEPTH   = 7;
    localparam int LATENCY = 2;
    localparam logic [DATA_W-1:0] INIT_VAL = '0;
    localparam int BUS_W = 2 + ADDR_W + DATA_W;
    localparam int NEVER = 1 << 30;

    localparam logic [1:0] RM  = 2'd0;
    localparam logic [1:0] WB  = 2'd1;
    localparam logic [1:0] WM  = 2'd2;
    localparam logic [1:0] INV = 2'd3;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              bus_valid = 1'b0;
    logic [BUS_W-1:0]  bus = '0;
    logic              bus_ready;
    logic [DATA_W-1:0] mem_out;
    logic              mem_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic              err;

    int n_checks = 0;
    int n_errors = 0;

    snoop_memory #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
        .LATENCY(LATENCY), .INIT_VAL(INIT_VAL)
    ) dut (
        .clock(clock), .reset(reset), .bus_valid(bus_valid), .bus(bus),
        .bus_ready(bus_ready), .mem_out(mem_out), .mem_valid(mem_valid),
        .mem_addr(mem_addr), .err(err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DATA_W-1:0] model_mem [0:(1<<ADDR_W)-1];
    int                cyc = 0;
    bit                known = 0;
    bit                prev_reset = 0;
    int                ready_from = NEVER;
    int                resp_cyc = -1;
    int                err_cyc = -1;
    logic [DATA_W-1:0] resp_data = '0;
    logic [ADDR_W-1:0] resp_addr = '0;
    logic [DATA_W-1:0] last_out = '0;
    logic [ADDR_W-1:0] last_addr = '0;
    logic [1:0]        m_op;
    logic [ADDR_W-1:0] m_a;
    logic [DATA_W-1:0] m_d;

    always @(negedge clock) begin
        m_op = bus[BUS_W-1 -: 2];
        m_a  = bus[DATA_W +: ADDR_W];
        m_d  = bus[DATA_W-1:0];
        if (!reset && prev_reset) begin
            ready_from = cyc + DEPTH;
            prev_reset = 0;
        end
        if (known) begin
            if (cyc == resp_cyc) begin
                last_out  = resp_data;
                last_addr = resp_addr;
            end
            check("bus_ready", 32'(bus_ready), 32'(cyc >= ready_from));
            check("mem_valid", 32'(mem_valid), 32'(cyc == resp_cyc));
            check("err",       32'(err),       32'(cyc == err_cyc));
            check("mem_out",   32'(mem_out),   32'(last_out));
            check("mem_addr",  32'(mem_addr),  32'(last_addr));
        end
        if (reset) begin
            known      = 1;
            prev_reset = 1;
            ready_from = NEVER;
            resp_cyc   = -1;
            err_cyc    = -1;
            last_out   = '0;
            last_addr  = '0;
            for (int i = 0; i < (1 << ADDR_W); i++) model_mem[i] = INIT_VAL;
        end else if (known && bus_valid && cyc >= ready_from) begin
            if (m_op != INV && int'(m_a) >= DEPTH) err_cyc = cyc + 1;
            if (m_op == RM || m_op == WM) begin
                resp_cyc   = cyc + LATENCY;
                resp_data  = (int'(m_a) < DEPTH) ? model_mem[m_a] : '0;
                resp_addr  = m_a;
                ready_from = cyc + LATENCY + 1;
            end else if (m_op == WB && int'(m_a) < DEPTH) begin
                model_mem[m_a] = m_d;
            end
        end
        cyc++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [1:0] op, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, output int stalls);
        bit acc;
        bit done;
        stalls = 0;
        done = 0;
        bus_valid = 1'b1;
        bus = {op, a, d};
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clock);
            acc = bus_ready;
            @(posedge clock);
            #1;
            if (acc) done = 1;
            else stalls++;
        end
        bus_valid = 1'b0;
        if (!done) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic read_expect(input logic [1:0] op, input logic [ADDR_W-1:0] a,
                               input logic [DATA_W-1:0] exp);
        int  st;
        bit  got;
        send(op, a, '0, st);
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clock);
            if (mem_valid) got = 1;
        end
        if (got) begin
            check("rd_data", 32'(mem_out), 32'(exp));
            check("rd_addr", 32'(mem_addr), 32'(a));
        end else begin
            check("rd_timeout", 32'd0, 32'd1);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int st;
        logic [1:0]        r_op;
        logic [ADDR_W-1:0] r_a;
        logic [DATA_W-1:0] r_d;

        do_reset(2);

        // Initialised contents
        for (int i = 0; i < DEPTH; i++) read_expect(RM, ADDR_W'(i), INIT_VAL);

        // Write then read back
        send(WB, 3'd5, 4'hA, st);
        read_expect(RM, 3'd5, 4'hA);

        // Write-miss read and invalidate
        send(WB, 3'd2, 4'h3, st);
        read_expect(WM, 3'd2, 4'h3);
        send(INV, 3'd2, 4'hF, st);
        read_expect(RM, 3'd2, 4'h3);

        // Out of range
        read_expect(RM, 3'd7, 4'h0);
        send(WB, 3'd7, 4'hF, st);
        read_expect(RM, 3'd7, 4'h0);
        read_expect(RM, 3'd6, INIT_VAL);

        // Write held during read wait
        send(RM, 3'd1, 4'h0, st);
        send(WB, 3'd1, 4'h9, st);
        check("hold_stalls", 32'(st), 32'(LATENCY));
        read_expect(RM, 3'd1, 4'h9);

        // Reset in the middle of a read
        send(RM, 3'd5, 4'h0, st);
        do_reset(1);
        read_expect(RM, 3'd5, INIT_VAL);

        // Randomized traffic
        for (int it = 0; it < 400; it++) begin
            r_op = 2'($urandom_range(0, 3));
            r_a  = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
            r_d  = DATA_W'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                do_reset($urandom_range(1, 3));
            end else if ($urandom_range(0, 9) < 2) begin
                bus_valid = 1'b1;
                bus = {r_op, r_a, r_d};
                @(posedge clock);
                #1;
                bus_valid = 1'b0;
            end else begin
                send(r_op, r_a, r_d, st);
            end
            repeat ($urandom_range(0, 2)) begin
                @(posedge clock);
                #1;
            end
        end

        repeat (LATENCY + 4) @(negedge clock);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/snoop_memory.md
Name: snoop_memory

Overview:
- Parametrised main-memory model for the snooping coherence bus; successor to the fixed 3-bit-tag / 4-bit-data memory.
- Services read-miss, write-miss (read-for-ownership), write-back and invalidate bus transactions.
- Adds a valid/ready handshake, configurable read latency, an out-of-range error flag, and a post-reset sweep that initialises every word.
- Sits on the shared bus beside the cache controllers; its read responses return to the requesting cache.

Parameters:
- ADDR_W, 3, tag/address width in bits.
- DATA_W, 4, data word width in bits.
- DEPTH, 7, number of implemented words; must satisfy 1 <= DEPTH <= 2**ADDR_W.
- LATENCY, 2, cycles from read acceptance to response; must be >= 1.
- INIT_VAL, 0, value written to every word by the reset sweep (DATA_W bits).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- bus_valid  in  1  a transaction is present on bus.
- bus  in  2+ADDR_W+DATA_W  fields: {op[1:0], addr[ADDR_W-1:0], data[DATA_W-1:0]}, op in the MSBs.
- bus_ready  out  1  memory accepts a transaction this cycle.
- mem_out  out  DATA_W  read response data.
- mem_valid  out  1  one-cycle pulse; mem_out is valid.
- mem_addr  out  ADDR_W  address of the transaction being answered.
- err  out  1  one-cycle pulse; the accepted transaction had addr >= DEPTH.

Behaviour:
- Acceptance: a transaction is accepted on the rising edge ending a cycle in which bus_valid && bus_ready; otherwise bus is ignored.
- op encoding:
  - 0 READ_MISS: read.
  - 1 WRITE_BACK: write data.
  - 2 WRITE_MISS: read, identical to READ_MISS.
  - 3 INVALIDATE: accepted, no memory effect, no response.
- FSM states: INIT, IDLE, READ_WAIT. bus_ready = (state == IDLE).
- Reset, while asserted, sets on the next edge:
  - state <= INIT, sweep counter <= 0;
  - mem_valid, err, bus_ready <= 0;
  - mem_out, mem_addr <= 0.
- Reset asserted in any state, including mid-read, aborts the operation; the pending response is never produced.
- INIT: one word per cycle, memory[counter] <= INIT_VAL. After DEPTH cycles with reset low, go to IDLE.
  - bus_ready first goes high in cycle DEPTH after reset release (cycle 0 = first cycle with reset low).
- IDLE, WRITE_BACK accepted at cycle t:
  - memory[addr] updated at the edge ending cycle t; state stays IDLE.
  - Back-to-back writes are accepted every cycle.
  - A read accepted at t+1 returns the new data.
- IDLE, READ_MISS/WRITE_MISS accepted at cycle t:
  - memory[addr] and addr are captured at the edge ending cycle t; state moves to READ_WAIT.
  - mem_valid = 1 in cycle t+LATENCY only, with mem_out = captured data and mem_addr = addr.
  - bus_ready = 0 in cycles t+1 .. t+LATENCY; back to IDLE, bus_ready = 1 at t+LATENCY+1.
- mem_out and mem_addr hold their last response values when mem_valid = 0.
- INVALIDATE accepted: state stays IDLE; no mem_valid pulse.
- Out-of-range addr (addr >= DEPTH), any op except INVALIDATE:
  - Read: mem_valid pulses at the normal time with mem_out = 0.
  - Write: dropped.
  - err = 1 in cycle t+1 only.
- Width rules:
  - addr is compared unsigned against DEPTH.
  - No arithmetic on data.
  - The sweep counter is wide enough to hold DEPTH without wrap, i.e. $clog2(DEPTH+1) bits.
- bus_valid while bus_ready = 0: ignored, not queued; the requester must hold the transaction.

Test Plan (default parameters):
- Reset 2 cycles, release -> bus_ready low for 7 cycles, high in cycle 7; reads of addr 0..6 each return 0.
- WRITE_BACK addr=5 data=4'hA, then READ_MISS addr=5 in the next cycle -> mem_valid exactly 2 cycles after read acceptance, mem_out=4'hA, mem_addr=5; bus_ready low those 2 cycles.
- WRITE_MISS addr=2 after a write of 4'h3 -> same response timing as READ_MISS, mem_out=4'h3; INVALIDATE addr=2 -> no mem_valid, and a subsequent read still returns 4'h3.
- READ_MISS addr=7 (out of range) -> err pulse in cycle t+1, mem_valid at t+2 with mem_out=0; WRITE_BACK addr=7 -> err pulse and no memory change.
- Hold bus_valid with a WRITE_BACK during READ_WAIT -> not accepted until the cycle after mem_valid; the write lands then.
- Assert reset in cycle t+1 of a read -> no mem_valid pulse; INIT sweep reruns; data previously written to addr 5 reads back as 0.
